hub75_row_driver: RTL
=====================

// Module: hub75_row_driver
// PURPOSE
//  Transmit-side driver for the LED panel's serial shift/latch interface: it
//  produces the data, shift clock, latch, output-enable and row-address signals
//  that the panel model (shift registers, latches, row decoders) consumes.
//  Rows are scanned in pairs (upper/lower half), with 1-bit colour per channel.
//  Pixel data comes from an external frame buffer that has a 1-cycle read latency.
// PARAMETERS
//  COLS        32  columns per row; one shifted pixel pair per column (>=2)
//  ROW_ADDR_W  4   row-address width; 2**ROW_ADDR_W scanned row pairs
//  CLK_DIV     2   clk cycles per sclk phase, low and high (>=2)
//  ON_CYCLES   64  clk cycles with n_oe low per row (>=1)
// PORTS
//  clk         in   1           system clock, rising edge
//  CLR         in   1           async active-low reset
//  en          in   1           scan enable, level-sensitive
//  pix_row     out  ROW_ADDR_W  frame-buffer read row (row pair index)
//  pix_col     out  clog2(COLS) frame-buffer read column
//  pix_rgb     in   6           {r1,g1,b1,r2,g2,b2}; valid 1 clk after address
//  rgb         out  6           panel data {r1,g1,b1,r2,g2,b2}
//  sclk        out  1           panel shift clock; panel samples on rising edge
//  lat         out  1           panel latch strobe, active high
//  n_oe        out  1           panel output enable, active low
//  addr        out  ROW_ADDR_W  panel row address
//  frame_done  out  1           1-clk pulse after the last row's DISPLAY ends
//  busy        out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset (CLR low, async, any state): state=IDLE, rgb=0, sclk=0, lat=0, n_oe=1,
//   addr=0, pix_row=0, pix_col=0, frame_done=0, busy=0. Row counter and column
//   counter = 0. All outputs are registered.
//  FSM: IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> (SHIFT | IDLE).
//  IDLE: n_oe=1, sclk=0. When en=1, go to SHIFT with col=0 on the next edge.
//  SHIFT: each column takes 2*CLK_DIV cycles, with phase counter k=0..2*CLK_DIV-1.
//   - k=0: pix_col=col, pix_row=row.
//   - k=1: rgb <= pix_rgb.
//   - k<CLK_DIV: sclk=0. k>=CLK_DIV: sclk=1.
//   - After the last k of column COLS-1: sclk=0, go to BLANK.
//   - n_oe=1 throughout SHIFT; rgb holds its value between updates.
//  BLANK: 1 cycle; n_oe=1, sclk=0, addr <= row.
//  LATCH: 2 cycles; lat=1. lat returns to 0 on entering DISPLAY.
//  DISPLAY: ON_CYCLES cycles with n_oe=0. On exit n_oe=1 and row <= row+1
//   (mod 2**ROW_ADDR_W).
//   - If row wrapped from max to 0, frame_done=1 for the next cycle.
//   - Next state is SHIFT if en=1, else IDLE. The row counter is not reset on
//     the IDLE path, so scanning resumes at the next row.
//  en is sampled only at IDLE and at DISPLAY exit; deasserting it mid-row
//   completes the row.
//  lat and sclk are never high simultaneously. n_oe is never low while lat=1,
//   while addr changes, or during SHIFT.
//  Row period = COLS*2*CLK_DIV + 1 + 2 + ON_CYCLES clk cycles.
//  Reset asserted mid-row abandons the row immediately; no partial latch occurs.
// TESTING
//  Params COLS=4, ROW_ADDR_W=2, CLK_DIV=2, ON_CYCLES=8 unless stated
//  (row period 27 cycles).
//  1 Reset: CLR=0 with en=1 -> rgb=0, sclk=0, lat=0, n_oe=1, addr=0, busy=0;
//    state stays IDLE.
//  2 One row: pix_rgb model returns col-dependent 6'h01<<col -> 4 sclk rises
//    with rgb=01,02,04,08. Then lat high for 2 cycles and n_oe low for exactly
//    8 cycles, with addr=0.
//  3 Frame scan: en=1 for 4 rows -> addr sequence 0,1,2,3. A single
//    frame_done pulse occurs 108 cycles after the start.
//  4 en dropped during SHIFT of row 1 -> row 1 completes (latch and display).
//    Then IDLE, busy=0; re-enabling resumes at row 2.
//  5 CLR pulsed during LATCH -> lat=0 and n_oe=1 immediately. On release,
//    scanning restarts at row 0, col 0.
//  6 Checker run over all tests: sclk&lat never 1, n_oe=0 only in DISPLAY,
//    and addr is stable whenever n_oe=0.

Source files
------------

// File: rtl/hub75_row_driver.sv
// hub75_row_driver: scans row pairs of a HUB75-style LED panel, shifting one
// pixel pair per column out of a frame buffer with 1-cycle read latency.
module hub75_row_driver #(
    parameter int COLS       = 32,
    parameter int ROW_ADDR_W = 4,
    parameter int CLK_DIV    = 2,
    parameter int ON_CYCLES  = 64
) (
    input  logic                    clk,
    input  logic                    CLR,
    input  logic                    en,
    output logic [ROW_ADDR_W-1:0]   pix_row,
    output logic [$clog2(COLS)-1:0] pix_col,
    input  logic [5:0]              pix_rgb,
    output logic [5:0]              rgb,
    output logic                    sclk,
    output logic                    lat,
    output logic                    n_oe,
    output logic [ROW_ADDR_W-1:0]   addr,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int COL_W = $clog2(COLS);
    localparam int K_W   = $clog2(2 * CLK_DIV);
    localparam int CNT_W = $clog2(ON_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_DISPLAY = 3'd4;

    localparam logic [K_W-1:0]        K_LAST      = K_W'(2 * CLK_DIV - 1);
    localparam logic [K_W-1:0]        K_SCLK_HI   = K_W'(CLK_DIV);
    localparam logic [K_W-1:0]        K_LOAD      = K_W'(1);
    localparam logic [COL_W-1:0]      COL_LAST    = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0]      CNT_ON_LAST = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_LAT_LAST = CNT_W'(1);
    localparam logic [ROW_ADDR_W-1:0] ROW_LAST    = '1;

    logic [2:0]            state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ROW_ADDR_W-1:0] row_q, row_d;

    logic [5:0]            rgb_q, rgb_d;
    logic                  sclk_q, sclk_d;
    logic                  lat_q, lat_d;
    logic                  n_oe_q, n_oe_d;
    logic [ROW_ADDR_W-1:0] addr_q, addr_d;
    logic [ROW_ADDR_W-1:0] pix_row_q, pix_row_d;
    logic [COL_W-1:0]      pix_col_q, pix_col_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_SHIFT;
                    k_d     = '0;
                    col_d   = '0;
                end
            end
            S_SHIFT: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (col_q == COL_LAST) begin
                        state_d = S_BLANK;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_BLANK: begin
                state_d = S_LATCH;
                cnt_d   = '0;
            end
            S_LATCH: begin
                if (cnt_q == CNT_LAT_LAST) begin
                    state_d = S_DISPLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DISPLAY: begin
                if (cnt_q == CNT_ON_LAST) begin
                    // Row advances even when stopping so a later enable resumes on the next row.
                    row_d        = row_q + 1'b1;
                    frame_done_d = (row_q == ROW_LAST);
                    k_d          = '0;
                    col_d        = '0;
                    state_d      = en ? S_SHIFT : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each registered output lines up with its state.
    always_comb begin
        sclk_d    = (state_d == S_SHIFT) && (k_d >= K_SCLK_HI);
        lat_d     = (state_d == S_LATCH);
        n_oe_d    = (state_d != S_DISPLAY);
        busy_d    = (state_d != S_IDLE);
        addr_d    = (state_d == S_BLANK) ? row_q : addr_q;
        pix_col_d = ((state_d == S_SHIFT) && (k_d == '0)) ? col_d : pix_col_q;
        pix_row_d = ((state_d == S_SHIFT) && (k_d == '0)) ? row_d : pix_row_q;
        rgb_d     = ((state_q == S_SHIFT) && (k_q == K_LOAD)) ? pix_rgb : rgb_q;
    end

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            row_q        <= '0;
            rgb_q        <= '0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            n_oe_q       <= 1'b1;
            addr_q       <= '0;
            pix_row_q    <= '0;
            pix_col_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            rgb_q        <= rgb_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            n_oe_q       <= n_oe_d;
            addr_q       <= addr_d;
            pix_row_q    <= pix_row_d;
            pix_col_q    <= pix_col_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign rgb        = rgb_q;
    assign sclk       = sclk_q;
    assign lat        = lat_q;
    assign n_oe       = n_oe_q;
    assign addr       = addr_q;
    assign pix_row    = pix_row_q;
    assign pix_col    = pix_col_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
